booth_mul_seq: RTL and testbench

- Iterative radix-4 Booth multiplier for the RV32M/RV64M multiply path.
- Generalises the fixed Booth cells into a parametrised sequential unit.
- Supports MUL, MULH, MULHSU and MULHU.
- Sits beside the execute stage and uses a valid/ready handshake, so the pipeline stalls while a multiply is in flight.

---
 rtl/booth_pkg.sv | 38 +++
 rtl/booth_recoder.sv | 40 ++++
 rtl/booth_mul_seq.sv | 157 +++++++++++++++
 tb/tb_booth_mul_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and the radix-4 digit decode for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_digit_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Window is {m[1], m[0], guard}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: turns a 3-bit multiplier window into a sign-extended
// partial product of the (XLEN+2)-bit multiplicand.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_win,
  input  logic [XLEN+1:0] i_mcand,
  output logic [XLEN+3:0] o_pp
);

  localparam int AW = XLEN + 4;

  booth_digit_e  dig;
  logic [AW-1:0] mag;
  logic          neg;

  always_comb begin
    dig = booth_decode(i_win);
    mag = '0;
    neg = 1'b0;
    case (dig)
      P1: mag = {{2{i_mcand[XLEN+1]}}, i_mcand};
      P2: mag = {i_mcand[XLEN+1], i_mcand, 1'b0};
      M1: begin
        mag = {{2{i_mcand[XLEN+1]}}, i_mcand};
        neg = 1'b1;
      end
      M2: begin
        mag = {i_mcand[XLEN+1], i_mcand, 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    // Negative digits: two's complement as invert plus carry-in.
    o_pp = (mag ^ {AW{neg}}) + {{(AW-1){1'b0}}, neg};
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready.
// Optional early exit on uniform remaining multiplier bits: BOOTH_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | ready for a request, operands latched on acceptance
// BUSY  | N_ITER Booth iterations, then one cycle to latch the product half
// DONE  | result valid, held until consumed or flushed
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int N_ITER = XLEN / 2 + 1;
  localparam int EW     = XLEN + 2;
  localparam int AW     = XLEN + 4;
  localparam int CW     = $clog2(N_ITER + 1);
  localparam int CHW    = AW + EW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [EW-1:0]   m_q, m_d;
  logic [EW-1:0]   mcand_q, mcand_d;
  logic            guard_q, guard_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mul_op_e         op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;

  mul_op_e         op_in;
  logic            rs1_sx, rs2_sx;
  logic [AW-1:0]   pp, acc_sum;
  logic [CHW-1:0]  chain_sh;
  logic [XLEN-1:0] prod_lo, prod_hi;
  logic            unused_acc_hi;

  assign op_in  = mul_op_e'(i_op);
  assign rs1_sx = (op_in != MULHU);
  assign rs2_sx = (op_in == MUL) || (op_in == MULH);

  booth_recoder #(.XLEN(XLEN)) u_recoder (
    .i_win  ({m_q[1:0], guard_q}),
    .i_mcand(mcand_q),
    .o_pp   (pp)
  );

  assign acc_sum  = acc_q + pp;
  assign chain_sh = {{2{acc_sum[AW-1]}}, acc_sum, m_q, guard_q} >> 2;

  // After all iterations the low EW product bits sit in m, the rest in acc.
  assign prod_lo       = m_q[XLEN-1:0];
  assign prod_hi       = {acc_q[XLEN-3:0], m_q[EW-1:XLEN]};
  assign unused_acc_hi = ^acc_q[AW-1:XLEN-2];

`ifdef BOOTH_EARLY_EXIT_EN
  logic [CW:0]            ee_shamt;
  logic [EW-1:0]          ee_mask;
  logic                   ee_hit;
  logic signed [CHW-1:0]  cur_chain;
  logic [CHW-1:0]         ee_chain;

  // Unconsumed multiplier bits are the low 2*(N_ITER-cnt) bits of m.
  assign ee_shamt  = {CW'(N_ITER) - cnt_q, 1'b0};
  assign ee_mask   = ~({EW{1'b1}} << ee_shamt);
  assign ee_hit    = ((m_q ^ {EW{guard_q}}) & ee_mask) == '0;
  assign cur_chain = {acc_q, m_q, guard_q};
  assign ee_chain  = cur_chain >>> ee_shamt;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    mcand_d = mcand_q;
    guard_d = guard_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid && !i_flush) begin
          mcand_d = {{2{rs1_sx & i_rs1[XLEN-1]}}, i_rs1};
          m_d     = {{2{rs2_sx & i_rs2[XLEN-1]}}, i_rs2};
          acc_d   = '0;
          guard_d = 1'b0;
          cnt_d   = '0;
          op_d    = op_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(N_ITER)) begin
          res_d   = (op_q == MUL) ? prod_lo : prod_hi;
          state_d = DONE;
        end
`ifdef BOOTH_EARLY_EXIT_EN
        else if (ee_hit) begin
          {acc_d, m_d, guard_d} = ee_chain;
          cnt_d = CW'(N_ITER);
        end
`endif
        else begin
          {acc_d, m_d, guard_d} = chain_sh;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_flush || i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      mcand_q <= '0;
      guard_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= MUL;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mcand_q <= mcand_d;
      guard_q <= guard_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign o_result = (state_q == DONE) ? res_q : '0;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (XLEN=32) with a result scoreboard.
module tb_booth_mul_seq;

  localparam int XLEN   = 32;
  localparam int N_ITER = XLEN / 2 + 1;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [1:0]      i_op = 2'd0;
  logic [XLEN-1:0] i_rs1 = '0;
  logic [XLEN-1:0] i_rs2 = '0;
  logic            i_flush = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [XLEN-1:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  booth_mul_seq #(.XLEN(XLEN)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN+1:0]   ea, eb;
    logic signed [2*XLEN+3:0] p;
    ea = {{2{(op != 2'd3) & a[XLEN-1]}}, a};
    eb = {{2{(op <= 2'd1) & b[XLEN-1]}}, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Cycles from the accepting edge to the edge after which o_valid is seen.
  function automatic int model_lat(input logic [1:0] op, input logic [XLEN-1:0] b);
`ifdef BOOTH_EARLY_EXIT_EN
    logic [XLEN+2:0] w;
    logic            sx;
    sx = (op <= 2'd1) & b[XLEN-1];
    w  = {sx, sx, b, 1'b0};
    for (int k = 0; k < N_ITER; k++) begin
      bit same;
      same = 1'b1;
      for (int j = 2 * k; j <= XLEN + 2; j++) if (w[j] != w[XLEN+2]) same = 1'b0;
      if (same) return k + 2;
    end
    return N_ITER + 1;
`else
    return N_ITER + 1;
`endif
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] expv, input int hold, input string name);
    int c;
    int lat;
    logic [XLEN-1:0] held;
    logic [XLEN-1:0] exp_r;
    lat = model_lat(op, b);
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: got %b want 1", name, o_ready);
    end
    i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    exp_q.push_back(expv);
    tick();
    i_valid = 1'b0;
    i_rs1 = $urandom; i_rs2 = $urandom; i_op = 2'($urandom_range(0, 3));
    c = 0;
    while (o_valid !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    n_tests++;
    if (c != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, c, lat);
    end
    held = o_result;
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1;
      tick();
      n_tests++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== held) begin
        n_fail++;
        $display("FAIL %s backpressure[%0d]: valid=%b ready=%b result=%h want 1 0 %h",
                 name, k, o_valid, o_ready, o_result, held);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    exp_r = exp_q.pop_front();
    n_tests++;
    if (o_valid !== 1'b1 || o_result !== exp_r) begin
      n_fail++;
      $display("FAIL %s result: valid=%b got %h want %h", name, o_valid, o_result, exp_r);
    end
    tick();
    i_ready = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== '0) begin
      n_fail++;
      $display("FAIL %s handoff: valid=%b ready=%b result=%h want 0 1 0",
               name, o_valid, o_ready, o_result);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (o_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s quiet: valid cycles=%0d ready=%b want 0 1", name, seen, o_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b result=%h want 0 1 0", o_valid, o_ready, o_result);
    end
    i_rst_n = 1'b1;
    tick();
    i_op = 2'd0; i_rs1 = 32'd1234; i_rs2 = 32'h5555_5555; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: valid=%b ready=%b result=%h want 0 1 0", o_valid, o_ready, o_result);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    do_op(2'd0, 32'd9, 32'd11, 32'd99, 0, "after_reset");
  endtask

  task automatic test_ops();
    do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
    do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
    do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
    do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
    do_op(2'd0, 32'd5, 32'd0, 32'd0, 0, "mul_5_0");
    do_op(2'd0, 32'd5, 32'd1, 32'd5, 0, "mul_5_1");
    do_op(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_max_m1");
  endtask

  task automatic test_backpressure();
    do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0), 10, "bp_mul");
  endtask

  task automatic test_flush();
    i_op = 2'd0; i_rs1 = 32'd3; i_rs2 = 32'd4; i_valid = 1'b1; i_flush = 1'b1;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    n_tests++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_accept: ready=%b want 1", o_ready);
    end
    expect_quiet(25, "flush_idle");

    i_op = 2'd0; i_rs1 = 32'd3; i_rs2 = 32'h5555_5555; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    expect_quiet(25, "flush_busy");

    i_op = 2'd3; i_rs1 = 32'd3; i_rs2 = 32'd4; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 40 && o_valid !== 1'b1; k++) tick();
    i_flush = 1'b1; i_ready = 1'b1;
    tick();
    i_flush = 1'b0; i_ready = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== '0) begin
      n_fail++;
      $display("FAIL flush_done: valid=%b ready=%b result=%h want 0 1 0", o_valid, o_ready, o_result);
    end
    expect_quiet(25, "flush_done");
    do_op(2'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0, "after_flush");
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] a, b;
    logic [1:0] op;
    for (int n = 0; n < 12; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (n % 4 == 1) b = '0;
      if (n % 4 == 2) b = {{(XLEN-3){b[XLEN-1]}}, b[2:0]};
      do_op(op, a, b, model(op, a, b), 0, $sformatf("b2b_%0d", n));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
